// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer and its receiver-side companions.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(MAX_WIDTH) + 1;

    // One spare bit above log2 keeps the counter from ever wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic first_bit(input logic [MAX_WIDTH-1:0] data,
                                       input int unsigned          width,
                                       input logic                 msb_first);
        if (msb_first) begin
            return data[width-1];
        end
        return data[0];
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load valid/ready handshake between an upstream controller and the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Bit counter with enable, synchronous clear and terminal-count flag at WIDTH-1.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tc
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready, shifts it out
// one bit per enabled clock, and flags completion with a one-cycle done pulse.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer_if.slave    load,
    input  logic                shift_enable,
    input  logic                abort,
    output logic                data_out,
    output logic                busy,
    output logic                done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shifted;
    logic             next_bit;
    logic             data_out_next;
    logic             done_next;
    logic             cnt_en;
    logic             cnt_clear;
    logic             last;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (reset),
        .en    (cnt_en),
        .clear (cnt_clear),
        .tc    (last)
    );

    // Deriving the next bit from the shifted value keeps WIDTH=1 legal.
    always_comb begin
        shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        next_bit = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        data_out_next = data_out;
        done_next     = 1'b0;
        cnt_en        = 1'b0;
        cnt_clear     = 1'b0;
        case (state)
            IDLE: begin
                data_out_next = 1'b0;
                if (load.load_valid) begin
                    shreg_next    = load.load_data;
                    data_out_next = first_bit(MAX_WIDTH'(load.load_data), WIDTH, MSB_FIRST);
                    cnt_clear     = 1'b1;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next    = IDLE;
                    data_out_next = 1'b0;
                    cnt_clear     = 1'b1;
                end else if (shift_enable) begin
                    if (last) begin
                        state_next    = IDLE;
                        data_out_next = 1'b0;
                        done_next     = 1'b1;
                        cnt_clear     = 1'b1;
                    end else begin
                        cnt_en        = 1'b1;
                        shreg_next    = shifted;
                        data_out_next = next_bit;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                data_out_next = 1'b0;
                cnt_clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            data_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            data_out <= data_out_next;
            done     <= done_next;
        end
    end

    // Ready is held low while reset is asserted so no word is offered into a held block.
    assign load.load_ready = (state == IDLE) && reset;
    assign busy            = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 8-bit MSB-first instance plus a WIDTH=1 instance.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic shift_enable;
    logic abort;
    logic data_out, busy, done;
    logic data_out1, busy1, done1;

    piso_serializer_if #(.WIDTH(8)) lif ();
    piso_serializer_if #(.WIDTH(1)) lif1 ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (lif.slave),
        .shift_enable (shift_enable),
        .abort        (abort),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .load         (lif1.slave),
        .shift_enable (shift_enable),
        .abort        (abort),
        .data_out     (data_out1),
        .busy         (busy1),
        .done         (done1)
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned done_pulses = 0;
    logic [7:0]  rx;

    // Receiver-side SIPO model sharing the link strobe.
    always_ff @(posedge clk) begin
        if (shift_enable) rx <= {rx[6:0], data_out};
        if (done) done_pulses <= done_pulses + 1;
    end

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        tick(2);
        total_cnt++; if (data_out !== 1'b0) $display("FAIL reset_data_out: got %b expected 0", data_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (lif.load_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", lif.load_ready); else pass_cnt++;
        lif.load_valid = 1'b0;
        shift_enable   = 1'b0;
        reset          = 1'b1;
        #1;
        total_cnt++; if (lif.load_ready !== 1'b1) $display("FAIL reset_ready_high: got %b expected 1", lif.load_ready); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    // Loads one word and walks it out; optional stall of stall_len cycles before bit index stall_after.
    task automatic send_word(input logic [7:0] word, input string tag,
                             input int unsigned stall_after, input int unsigned stall_len);
        int unsigned base;
        base = done_pulses;
        lif.load_valid = 1'b1;
        lif.load_data  = word;
        shift_enable   = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        abort          = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL %s_accept_busy: got %b expected 1", tag, busy); else pass_cnt++;
        total_cnt++; if (lif.load_ready !== 1'b0) $display("FAIL %s_accept_ready: got %b expected 0", tag, lif.load_ready); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_after) begin
                shift_enable = 1'b0;
                repeat (stall_len) begin
                    total_cnt++; if (data_out !== word[7-i]) $display("FAIL %s_stall_hold: got %b expected %b", tag, data_out, word[7-i]); else pass_cnt++;
                    total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL %s_stall_busy_done: got %b expected 10", tag, {busy, done}); else pass_cnt++;
                    tick();
                end
                shift_enable = 1'b1;
            end
            total_cnt++; if (data_out !== word[7-i]) $display("FAIL %s_bit%0d: got %b expected %b", tag, i, data_out, word[7-i]); else pass_cnt++;
            total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL %s_bit%0d_busy_done: got %b expected 10", tag, i, {busy, done}); else pass_cnt++;
            tick();
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL %s_done: got %b expected 1", tag, done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL %s_done_busy: got %b expected 0", tag, busy); else pass_cnt++;
        total_cnt++; if (data_out !== 1'b0) $display("FAIL %s_done_data: got %b expected 0", tag, data_out); else pass_cnt++;
        total_cnt++; if (lif.load_ready !== 1'b1) $display("FAIL %s_done_ready: got %b expected 1", tag, lif.load_ready); else pass_cnt++;
        total_cnt++; if (rx !== word) $display("FAIL %s_rx_word: got %h expected %h", tag, rx, word); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL %s_done_width: got %b expected 0", tag, done); else pass_cnt++;
        total_cnt++; if (done_pulses - base !== 1) $display("FAIL %s_done_count: got %0d expected 1", tag, done_pulses - base); else pass_cnt++;
    endtask

    task automatic test_msb_first;
        send_word(8'hA5, "msb", 8, 0);
    endtask

    task automatic test_stall;
        send_word(8'h3C, "stall", 3, 5);
    endtask

    task automatic test_back_to_back;
        int unsigned base;
        base = done_pulses;
        lif.load_valid = 1'b1;
        lif.load_data  = 8'hFF;
        shift_enable   = 1'b1;
        tick();
        lif.load_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if ({busy, done, data_out} !== 3'b101) $display("FAIL b2b_w0_bit%0d: got %b expected 101", i, {busy, done, data_out}); else pass_cnt++;
            tick();
        end
        total_cnt++; if ({busy, done, data_out, lif.load_ready} !== 4'b0101) $display("FAIL b2b_gap: got %b expected 0101", {busy, done, data_out, lif.load_ready}); else pass_cnt++;
        tick();
        lif.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total_cnt++; if ({busy, done, data_out} !== 3'b100) $display("FAIL b2b_w1_bit%0d: got %b expected 100", i, {busy, done, data_out}); else pass_cnt++;
            tick();
        end
        total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL b2b_w1_done: got %b expected 01", {busy, done}); else pass_cnt++;
        tick();
        total_cnt++; if (done_pulses - base !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_pulses - base); else pass_cnt++;
    endtask

    task automatic test_abort;
        int unsigned base;
        base = done_pulses;
        lif.load_valid = 1'b1;
        lif.load_data  = 8'hF0;
        shift_enable   = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        tick(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++; if ({busy, done, data_out, lif.load_ready} !== 4'b0001) $display("FAIL abort_idle: got %b expected 0001", {busy, done, data_out, lif.load_ready}); else pass_cnt++;
        tick();
        total_cnt++; if (done_pulses - base !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_pulses - base); else pass_cnt++;
        // abort held in IDLE must not block acceptance of the next word
        abort = 1'b1;
        send_word(8'h81, "abort_next", 8, 0);
    endtask

    task automatic test_reset_mid;
        int unsigned base;
        base = done_pulses;
        lif.load_valid = 1'b1;
        lif.load_data  = 8'hF0;
        shift_enable   = 1'b1;
        tick();
        lif.load_valid = 1'b0;
        tick(2);
        total_cnt++; if (data_out !== 1'b1) $display("FAIL rstmid_pre_data: got %b expected 1", data_out); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if ({busy, done, data_out, lif.load_ready} !== 4'b0000) $display("FAIL rstmid_async: got %b expected 0000", {busy, done, data_out, lif.load_ready}); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rstmid_after: got %b expected 00", {busy, done}); else pass_cnt++;
        total_cnt++; if (done_pulses - base !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", done_pulses - base); else pass_cnt++;
        send_word(8'h81, "rstmid_next", 8, 0);
    endtask

    task automatic test_loopback;
        send_word(8'h96, "loop", 8, 0);
    endtask

    task automatic test_width1;
        shift_enable    = 1'b0;
        lif1.load_valid = 1'b1;
        lif1.load_data  = 1'b1;
        tick();
        lif1.load_valid = 1'b0;
        total_cnt++; if ({busy1, data_out1} !== 2'b11) $display("FAIL w1_accept: got %b expected 11", {busy1, data_out1}); else pass_cnt++;
        tick();
        total_cnt++; if ({busy1, done1, data_out1} !== 3'b101) $display("FAIL w1_stall: got %b expected 101", {busy1, done1, data_out1}); else pass_cnt++;
        shift_enable = 1'b1;
        tick();
        total_cnt++; if ({busy1, done1, data_out1} !== 3'b010) $display("FAIL w1_done: got %b expected 010", {busy1, done1, data_out1}); else pass_cnt++;
        tick();
        total_cnt++; if (done1 !== 1'b0) $display("FAIL w1_done_width: got %b expected 0", done1); else pass_cnt++;
    endtask

    initial begin
        reset           = 1'b0;
        shift_enable    = 1'b1;
        abort           = 1'b0;
        lif.load_valid  = 1'b1;
        lif.load_data   = 8'h5A;
        lif1.load_valid = 1'b0;
        lif1.load_data  = 1'b0;
        test_reset();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_loopback();
        test_width1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
